flash_be_ctrl: RTL and testbench

SPI-flash bulk-erase sequencer. Sits directly downstream of the key debounce stage. A one-cycle `key_flag` pulse starts the sequence:

- Write Enable (0x06)
- Bulk Erase (0xC7)
- Repeated Read Status Register (0x05) polls until the WIP bit clears

The block drives the flash pins directly in SPI mode 0 and reports completion with a one-cycle `done` pulse.

---
 rtl/flash_be_ctrl.sv | 137 +++++++++++++
 tb/tb_flash_be_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_be_ctrl.sv
// SPI-flash bulk-erase sequencer: WREN, BE, then RDSR polling until WIP clears.
// Drives the flash pins in SPI mode 0; all outputs come straight from flops.
module flash_be_ctrl #(
   parameter int SCK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_flag,
   input  logic miso,
   output logic cs_n,
   output logic sck,
   output logic mosi,
   output logic busy,
   output logic done
);

   localparam int DIV_W = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, WREN, GAP_WE, BE, GAP_BE, RDSR, GAP_POLL, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [4:0]       bit_q, bit_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]       rx_q, rx_d;
   logic             cs_n_q, sck_q, mosi_q, busy_q, done_q;
   logic             cs_n_d, sck_d, mosi_d, busy_d, done_d;
   logic [4:0]       lastBit;
   logic [4:0]       dataBits;
   logic             inFrame;
   logic [7:0]       txByte;

   // Sequencing: bit_q counts bits of the frame, with bit index 8N being the tail.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      rx_d    = rx_q;
      lastBit = (state_q == RDSR) ? 5'd16 : 5'd8;
      case (state_q)
         IDLE: begin
            if (key_flag) begin
               state_d = WREN;
               div_d   = '0;
               bit_d   = '0;
            end
         end
         WREN, BE, RDSR: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_q == lastBit) begin
                  gap_d = '0;
                  if (state_q == WREN)    state_d = GAP_WE;
                  else if (state_q == BE) state_d = GAP_BE;
                  else                    state_d = rx_q[0] ? GAP_POLL : DONE;
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GAP_WE, GAP_BE, GAP_POLL: begin
            if (gap_q == GAP_LAST) begin
               state_d = (state_q == GAP_WE) ? BE : RDSR;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q == RDSR && div_q == DIV_LAST && bit_q < 5'd16) begin
         rx_d = {rx_q[6:0], miso};
      end
   end

   // Pin values are derived from the next state so they appear in the same cycle as the state.
   always_comb begin
      inFrame  = (state_d == WREN) || (state_d == BE) || (state_d == RDSR);
      dataBits = (state_d == RDSR) ? 5'd16 : 5'd8;
      case (state_d)
         WREN:    txByte = 8'h06;
         BE:      txByte = 8'hC7;
         RDSR:    txByte = bit_d[3] ? 8'h00 : 8'h05;
         default: txByte = 8'h00;
      endcase
      cs_n_d = !inFrame;
      sck_d  = inFrame && (bit_d < dataBits) && (div_d >= DIV_HALF);
      mosi_d = inFrame && (bit_d < dataBits) && txByte[3'd7 - bit_d[2:0]];
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         rx_q    <= '0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         rx_q    <= rx_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign cs_n = cs_n_q;
   assign sck  = sck_q;
   assign mosi = mosi_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_flash_be_ctrl.sv
// Bench for flash_be_ctrl: three instances (SCK_DIV 4/2/8), each with a flash model and protocol monitor.
// Expected frames and done latency come from the command sequence and the latency formula.
module tb_flash_be_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key = 1'b0;
   logic monClear = 1'b0;
   int   edgeCnt = 0;
   int   startEdge = 0;
   int   curCyc = 0;
   int   tests = 0;
   int   fails = 0;
   logic [7:0] plan[$];

   always #5 clk = ~clk;
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int SD = (g == 0) ? 4 : (g == 1) ? 2 : 8;
      localparam int CG = (g == 0) ? 8 : (g == 1) ? 3 : 1;
      logic csN, sck, mosi, busy, done;
      logic miso = 1'b0;
      logic [7:0] mBytes[$];
      int   lens[$];
      int   doneQ[$];
      int   protoErr = 0;
      int   bitN = 0, lowLen = 0, gapLen = 0, rdsrIdx = 0;
      logic [7:0] cmd = 8'h00, shiftB = 8'h00, stat = 8'h00;
      logic pCs = 1'b1, pSck = 1'b0, pMosi = 1'b0, pRst = 1'b0;
      logic firstFrame = 1'b1, sawDone = 1'b0;

      flash_be_ctrl #(.SCK_DIV(SD), .CS_GAP(CG)) dut (
         .sys_clk(clk), .sys_rst(rst), .key_flag(key), .miso(miso),
         .cs_n(csN), .sck(sck), .mosi(mosi), .busy(busy), .done(done)
      );

      // Flash model plus pin-level protocol monitor, sampled mid-cycle.
      always @(negedge clk) begin
         if (monClear) begin
            mBytes.delete();
            lens.delete();
            doneQ.delete();
            protoErr   = 0;
            rdsrIdx    = 0;
            firstFrame = 1'b1;
            sawDone    = 1'b0;
         end
         if (done) begin
            doneQ.push_back(edgeCnt);
            sawDone = 1'b1;
         end
         if (csN && sck) protoErr++;
         if ((csN != pCs) && !pRst && (sck || pSck)) protoErr++;
         if (!csN && pCs) begin
            if (!firstFrame && !sawDone && gapLen < CG) protoErr++;
            firstFrame = 1'b0;
            sawDone    = 1'b0;
            bitN       = 0;
            cmd        = 8'h00;
            shiftB     = 8'h00;
            lowLen     = 0;
         end
         if (csN && !pCs) begin
            if (!pRst) lens.push_back(lowLen);
            if (!pRst && cmd == 8'h05 && bitN >= 16) rdsrIdx++;
            gapLen = 0;
            miso   = 1'b0;
         end
         if (!csN) begin
            lowLen++;
            if (sck && !pSck) begin
               if (mosi != pMosi) protoErr++;
               bitN++;
               shiftB = {shiftB[6:0], mosi};
               if (bitN == 8) cmd = shiftB;
               if (bitN % 8 == 0) mBytes.push_back(shiftB);
               stat = (rdsrIdx < plan.size()) ? plan[rdsrIdx] : 8'h00;
               miso = (cmd == 8'h05 && bitN >= 9 && bitN <= 16) ? stat[16 - bitN] : 1'b0;
            end
         end else begin
            gapLen++;
         end
         pCs   = csN;
         pSck  = sck;
         pMosi = mosi;
         pRst  = rst;
      end
   end

   typedef struct {
      int         cyc;
      logic [4:0] exp;
   } vec_t;
   vec_t vecs[$];
   logic [4:0] obs[0:200];

   task automatic checkVal(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int wipPolls();
      for (int i = 0; i < plan.size(); i++) begin
         if (plan[i][0] == 1'b0) return i;
      end
      return plan.size();
   endfunction

   function automatic logic [4:0] mainPins();
      return {gi[0].csN, gi[0].sck, gi[0].mosi, gi[0].busy, gi[0].done};
   endfunction

   task automatic gotoCycle(input int c);
      while (curCyc < c) begin
         @(negedge clk);
         curCyc++;
      end
   endtask

   task automatic clearMon();
      @(posedge clk);
      monClear = 1'b1;
      @(posedge clk);
      monClear = 1'b0;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      key = 1'b1;
      @(negedge clk);
      key = 1'b0;
      startEdge = edgeCnt;
      curCyc = 1;
   endtask

   task automatic waitIdle();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!gi[0].busy && !gi[1].busy && !gi[2].busy) begin
            ok = 1'b1;
            break;
         end
      end
      checkVal("idle timeout", int'(ok), 1);
   endtask

   task automatic checkOutput(input string tag, input int sd, input int cg, input int p,
                              input logic [7:0] bq[$], input int lq[$], input int dq[$],
                              input int perr);
      int bad = 0;
      int badLen = 0;
      logic [7:0] expB;
      checkVal({tag, " frame count"}, lq.size(), 3 + p);
      checkVal({tag, " byte count"}, bq.size(), 4 + 2 * p);
      for (int i = 0; i < bq.size(); i++) begin
         expB = (i == 0) ? 8'h06 : (i == 1) ? 8'hC7 : (i % 2 == 0) ? 8'h05 : 8'h00;
         if (bq[i] != expB) bad++;
      end
      checkVal({tag, " bad bytes"}, bad, 0);
      for (int i = 0; i < lq.size(); i++) begin
         if (lq[i] != ((i < 2) ? 9 * sd : 17 * sd)) badLen++;
      end
      checkVal({tag, " bad frame lengths"}, badLen, 0);
      checkVal({tag, " done pulses"}, dq.size(), 1);
      checkVal({tag, " done latency"}, (dq.size() > 0) ? dq[0] - startEdge + 1 : -1,
               1 + 18 * sd + 17 * sd + 2 * cg + p * (17 * sd + cg));
      checkVal({tag, " protocol errors"}, perr, 0);
   endtask

   task automatic checkAll(input string tag);
      int p = wipPolls();
      checkOutput({tag, "/div4"}, 4, 8, p, gi[0].mBytes, gi[0].lens, gi[0].doneQ, gi[0].protoErr);
      checkOutput({tag, "/div2"}, 2, 3, p, gi[1].mBytes, gi[1].lens, gi[1].doneQ, gi[1].protoErr);
      checkOutput({tag, "/div8"}, 8, 1, p, gi[2].mBytes, gi[2].lens, gi[2].doneQ, gi[2].protoErr);
   endtask

   initial begin
      int busyCnt;
      int r;
      vecs = '{
         '{1, 5'b00010}, '{2, 5'b00010}, '{3, 5'b01010}, '{21, 5'b00110}, '{23, 5'b01110},
         '{27, 5'b01110}, '{29, 5'b00010}, '{33, 5'b00010}, '{36, 5'b00010}, '{37, 5'b10010},
         '{44, 5'b10010}, '{45, 5'b00110}, '{47, 5'b01110}, '{53, 5'b00010}, '{75, 5'b01110},
         '{80, 5'b00010}, '{81, 5'b10010}, '{88, 5'b10010}, '{89, 5'b00010}, '{111, 5'b01110},
         '{115, 5'b01010}, '{119, 5'b01110}, '{123, 5'b01010}, '{156, 5'b00010},
         '{157, 5'b10011}, '{158, 5'b10000}
      };

      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkVal("reset pins {cs,sck,mosi,busy,done}", int'(mainPins()), int'(5'b10000));

      // Basic erase with cycle-exact pin table.
      plan = '{8'h00};
      clearMon();
      applyStimulus();
      obs[1] = mainPins();
      for (int c = 2; c <= 158; c++) begin
         gotoCycle(c);
         obs[c] = mainPins();
      end
      for (int i = 0; i < vecs.size(); i++) begin
         checkVal($sformatf("pins@cycle%0d", vecs[i].cyc), int'(obs[vecs[i].cyc]), int'(vecs[i].exp));
      end
      busyCnt = 0;
      for (int c = 1; c <= 158; c++) busyCnt += int'(obs[c][1]);
      checkVal("busy cycle count", busyCnt, 157);
      waitIdle();
      checkAll("basic");

      plan = '{8'h03, 8'h03, 8'h00};
      clearMon();
      applyStimulus();
      waitIdle();
      checkAll("poll");
      checkVal("poll div4 done@309", (gi[0].doneQ.size() > 0) ? gi[0].doneQ[0] - startEdge + 1 : -1, 309);

      plan = '{8'hFE};
      clearMon();
      applyStimulus();
      waitIdle();
      checkAll("wipFE");

      // Requests while busy and during DONE are dropped.
      plan = '{8'h00};
      clearMon();
      applyStimulus();
      gotoCycle(20);
      key = 1'b1;
      gotoCycle(21);
      key = 1'b0;
      gotoCycle(157);
      checkVal("ignore done@157", int'(gi[0].done), 1);
      key = 1'b1;
      gotoCycle(158);
      key = 1'b0;
      gotoCycle(200);
      checkVal("ignore no restart {cs,busy}", int'({gi[0].csN, gi[0].busy}), 2);
      waitIdle();
      checkVal("ignore done pulses", gi[0].doneQ.size(), 1);
      checkVal("ignore byte count", gi[0].mBytes.size(), 4);

      // Back-to-back request right after DONE.
      clearMon();
      applyStimulus();
      gotoCycle(158);
      checkVal("b2b cs@158", int'(gi[0].csN), 1);
      key = 1'b1;
      gotoCycle(159);
      key = 1'b0;
      checkVal("b2b cs@159", int'(gi[0].csN), 0);
      waitIdle();
      checkVal("b2b done pulses", gi[0].doneQ.size(), 2);
      checkVal("b2b second latency", (gi[0].doneQ.size() > 1) ? gi[0].doneQ[1] - startEdge + 1 : -1, 315);
      checkVal("b2b byte count", gi[0].mBytes.size(), 8);

      // Reset inside BE frame.
      clearMon();
      applyStimulus();
      gotoCycle(49);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      curCyc = 50;
      checkVal("rst cs/busy@50", int'({gi[0].csN, gi[0].busy}), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkVal("rst pins@51", int'(mainPins()), int'(5'b10000));
      checkVal("rst busy others", int'({gi[1].busy, gi[2].busy}), 0);
      repeat (5) @(negedge clk);
      clearMon();
      applyStimulus();
      waitIdle();
      checkAll("afterRst");

      // Randomized status sequences with stray requests while busy.
      for (int it = 0; it < 8; it++) begin
         plan.delete();
         r = $urandom_range(0, 3);
         for (int i = 0; i < r; i++) plan.push_back(8'($urandom) | 8'h01);
         plan.push_back(8'($urandom) & 8'hFE);
         clearMon();
         applyStimulus();
         gotoCycle($urandom_range(3, 6));
         key = 1'b1;
         gotoCycle(curCyc + 1);
         key = 1'b0;
         waitIdle();
         checkAll($sformatf("rand%0d", it));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
